// File: rtl/dyn_gate_sequencer_pkg.sv
// dyn_gate_sequencer_pkg
//  Shared definitions for the dynamic-gate sequencer: FSM state encoding
//  and the phase-length clamp used to turn a 0-cycle request into 1 cycle.
package dyn_gate_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_EVAL = 3'd2,
        ST_SAMP = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // A phase of length 0 would skip the phase entirely; run it for one cycle instead.
    function automatic int unsigned phase_len(input int unsigned n);
        return (n == 0) ? 1 : n;
    endfunction

endpackage

// File: rtl/dyn_gate_sequencer_if.sv
// dyn_gate_sequencer_if
//  Bundles the requester handshake (start/a/b/c -> busy/done/result) and the
//  switch-level gate drive (pch_n/eval_en/ga/gb/gc <- y_in).
//  Modports: slave = the sequencer, master = the environment (requester + gate).
//  Optional macro DYN_SEQ_CHECK_EN adds exp_y (to sequencer) and err (from sequencer).
interface dyn_gate_sequencer_if;
    logic start;
    logic a, b, c;
    logic busy;
    logic done;
    logic result;
    logic pch_n;
    logic eval_en;
    logic ga, gb, gc;
    logic y_in;
`ifdef DYN_SEQ_CHECK_EN
    logic exp_y;
    logic err;
`endif

    modport slave (
        input  start, a, b, c, y_in,
`ifdef DYN_SEQ_CHECK_EN
        input  exp_y,
        output err,
`endif
        output busy, done, result, pch_n, eval_en, ga, gb, gc
    );

    modport master (
        output start, a, b, c, y_in,
`ifdef DYN_SEQ_CHECK_EN
        output exp_y,
        input  err,
`endif
        input  busy, done, result, pch_n, eval_en, ga, gb, gc
    );
endinterface

// File: rtl/dyn_gate_sequencer_phase_cnt.sv
// dyn_gate_sequencer_phase_cnt
//  Loadable down-counter timing the PRE and EVAL phases.
//  Ports: clk, rst (sync, active high), load/load_val (load takes priority),
//         dec (decrement, saturates at 0), zero (count == 0).
module dyn_gate_sequencer_phase_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/dyn_gate_sequencer.sv
// dyn_gate_sequencer
//  Runs one precharge/evaluate cycle of a 3-input domino gate per request:
//  IDLE -> PRE (PCH_CYC) -> EVAL (EVAL_CYC) -> SAMP -> DONE -> IDLE.
//  Ports: clk, rst (sync, active high), bus (dyn_gate_sequencer_if.slave):
//    start/a/b/c in, busy/done/result out (requester side),
//    pch_n/eval_en/ga/gb/gc out, y_in in (gate side).
//  Optional macro DYN_SEQ_CHECK_EN: exp_y latched at accept, err flags
//  result != exp_y from DONE until the next accept.
//  Every output is a flop loaded from the next-state decode, so nothing on
//  the requester inputs reaches an output combinationally.
module dyn_gate_sequencer
    import dyn_gate_sequencer_pkg::*;
#(
    parameter int PCH_CYC  = 2,
    parameter int EVAL_CYC = 3,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    dyn_gate_sequencer_if.slave bus
);
    localparam int unsigned      PCH_LEN  = phase_len(PCH_CYC);
    localparam int unsigned      EVAL_LEN = phase_len(EVAL_CYC);
    localparam logic [CNT_W-1:0] PCH_LD   = CNT_W'(PCH_LEN - 1);
    localparam logic [CNT_W-1:0] EVAL_LD  = CNT_W'(EVAL_LEN - 1);

    state_t           state, state_nx;
    logic             accept;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_ld_val;
    logic [2:0]       op_q;
    logic             eval_nx;

    logic             busy_q, done_q, result_q, pch_n_q, eval_en_q;
    logic [2:0]       g_q;

    dyn_gate_sequencer_phase_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_ld_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nx   = state;
        accept     = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_ld_val = PCH_LD;
        case (state)
            ST_IDLE: if (bus.start) begin
                accept   = 1'b1;
                cnt_load = 1'b1;
                state_nx = ST_PRE;
            end
            ST_PRE: if (cnt_zero) begin
                cnt_load   = 1'b1;
                cnt_ld_val = EVAL_LD;
                state_nx   = ST_EVAL;
            end else begin
                cnt_dec = 1'b1;
            end
            ST_EVAL: if (cnt_zero) state_nx = ST_SAMP;
                     else          cnt_dec  = 1'b1;
            ST_SAMP: state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // pch_n and eval_en share one flop source, so the pmos and footer can
    // never be on together; gate inputs only move entering/leaving EVAL.
    assign eval_nx = (state_nx == ST_EVAL) || (state_nx == ST_SAMP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= 1'b0;
            pch_n_q   <= 1'b0;
            eval_en_q <= 1'b0;
            g_q       <= '0;
        end else begin
            state     <= state_nx;
            if (accept)
                op_q <= {bus.a, bus.b, bus.c};
            busy_q    <= (state_nx != ST_IDLE);
            done_q    <= (state_nx == ST_DONE);
            pch_n_q   <= eval_nx;
            eval_en_q <= eval_nx;
            g_q       <= eval_nx ? op_q : 3'b000;
            // y_in is taken as-is, including X/Z, at the end of SAMP.
            if (state == ST_SAMP)
                result_q <= bus.y_in;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.pch_n   = pch_n_q;
    assign bus.eval_en = eval_en_q;
    assign bus.ga      = g_q[2];
    assign bus.gb      = g_q[1];
    assign bus.gc      = g_q[0];

`ifdef DYN_SEQ_CHECK_EN
    logic exp_q, err_q;

    // Comparing y_in at the end of SAMP lands err in DONE, alongside result.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q <= 1'b0;
            err_q <= 1'b0;
        end else if (accept) begin
            exp_q <= bus.exp_y;
            err_q <= 1'b0;
        end else if (state == ST_SAMP) begin
            err_q <= (bus.y_in != exp_q);
        end
    end

    assign bus.err = err_q;
`endif
endmodule

// File: tb/tb_dyn_gate_sequencer.sv
// tb_dyn_gate_sequencer
//  Directed bench for dyn_gate_sequencer with default parameters and a
//  majority-gate model on the gate side. Cycle k counts from the accept edge
//  (the op accepted at the end of cycle 0); PRE = 1-2, EVAL = 3-5, SAMP = 6,
//  DONE = 7. With start held high the next accept is in the IDLE cycle after
//  DONE, so back-to-back ops repeat every 8 cycles (DONE at 7, 15, 23).
module tb_dyn_gate_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stuck0 = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    dyn_gate_sequencer_if bus ();

    dyn_gate_sequencer u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.y_in = stuck0 ? 1'b0 :
        (bus.eval_en & ((bus.ga & bus.gb) | (bus.gb & bus.gc) | (bus.ga & bus.gc)));

    localparam int TL = 24;
    logic [TL-1:0] t_pch, t_eval, t_done, t_busy, t_res, t_err;
    logic [2:0]    t_g [TL];

    typedef struct {
        logic [2:0] op;
        logic       exp_res;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Accept op1 at the end of cycle 0, then record TL cycles of outputs.
    // start/rst for cycle k come from the masks; operands switch to op2 at cycle 8.
    task automatic run_seq(input logic [2:0] op1, input logic [2:0] op2,
                           input logic [TL-1:0] start_m, input logic [TL-1:0] rst_m);
        @(negedge clk);
        {bus.a, bus.b, bus.c} = op1;
        bus.start = start_m[0];
        rst = rst_m[0];
        for (int k = 1; k < TL; k++) begin
            @(negedge clk);
            t_pch[k]  = bus.pch_n;
            t_eval[k] = bus.eval_en;
            t_done[k] = bus.done;
            t_busy[k] = bus.busy;
            t_res[k]  = bus.result;
            t_g[k]    = {bus.ga, bus.gb, bus.gc};
`ifdef DYN_SEQ_CHECK_EN
            t_err[k]  = bus.err;
`else
            t_err[k]  = 1'b0;
`endif
            bus.start = start_m[k];
            rst       = rst_m[k];
            {bus.a, bus.b, bus.c} = (k >= 8) ? op2 : op1;
        end
        bus.start = 1'b0;
        rst = 1'b0;
        t_pch[0] = 1'b0; t_eval[0] = 1'b0; t_done[0] = 1'b0;
        t_busy[0] = 1'b0; t_res[0] = 1'b0; t_err[0] = 1'b0; t_g[0] = 3'b000;
    endtask

    vec_t vecs [6];

    initial begin
        bus.start = 1'b0;
        {bus.a, bus.b, bus.c} = 3'b000;
`ifdef DYN_SEQ_CHECK_EN
        bus.exp_y = 1'b0;
`endif
        vecs[0] = '{op: 3'b110, exp_res: 1'b1};
        vecs[1] = '{op: 3'b000, exp_res: 1'b0};
        vecs[2] = '{op: 3'b101, exp_res: 1'b1};
        vecs[3] = '{op: 3'b010, exp_res: 1'b0};
        vecs[4] = '{op: 3'b001, exp_res: 1'b0};
        vecs[5] = '{op: 3'b111, exp_res: 1'b1};

        // Reset: two cycles high.
        repeat (2) @(negedge clk);
        chk("rst_pch_n",   32'(bus.pch_n),   32'd0);
        chk("rst_eval_en", 32'(bus.eval_en), 32'd0);
        chk("rst_busy",    32'(bus.busy),    32'd0);
        chk("rst_done",    32'(bus.done),    32'd0);
        chk("rst_result",  32'(bus.result),  32'd0);
        chk("rst_g",       32'({bus.ga, bus.gb, bus.gc}), 32'd0);
        rst = 1'b0;

        // Single ops from the table.
        for (int i = 0; i < 6; i++) begin
            run_seq(vecs[i].op, vecs[i].op, 24'h000001, 24'h0);
            chk($sformatf("v%0d_pch_n", i),   32'(t_pch),  32'h000078);
            chk($sformatf("v%0d_eval_en", i), 32'(t_eval), 32'h000078);
            chk($sformatf("v%0d_busy", i),    32'(t_busy), 32'h0000FE);
            chk($sformatf("v%0d_done", i),    32'(t_done), 32'h000080);
            chk($sformatf("v%0d_g_pre", i),   32'(t_g[2]), 32'd0);
            chk($sformatf("v%0d_g_eval", i),  32'(t_g[4]), 32'(vecs[i].op));
            chk($sformatf("v%0d_g_done", i),  32'(t_g[7]), 32'd0);
            chk($sformatf("v%0d_result", i),  32'(t_res[7]), 32'(vecs[i].exp_res));
            chk($sformatf("v%0d_res_hold", i), 32'(t_res[20]), 32'(vecs[i].exp_res));
        end

        // Reset in cycle 4; last table op left result=1.
        run_seq(3'b111, 3'b111, 24'h000001, 24'h000010);
        chk("mrst_res_before", 32'(t_res[4]), 32'd1);
        chk("mrst_res_after",  32'(t_res[5]), 32'd0);
        chk("mrst_pch_n",      32'(t_pch),    32'h000018);
        chk("mrst_eval_en",    32'(t_eval),   32'h000018);
        chk("mrst_busy",       32'(t_busy),   32'h00001E);
        chk("mrst_done",       32'(t_done),   32'h000000);

        // start pulsed again in cycles 3 (busy) and 7 (DONE): ignored.
        run_seq(3'b110, 3'b000, 24'h000089, 24'h0);
        chk("ign_done",   32'(t_done), 32'h000080);
        chk("ign_busy",   32'(t_busy), 32'h0000FE);
        chk("ign_result", 32'(t_res[7]), 32'd1);

        // start held high for 20 cycles: re-accepts after each DONE.
        run_seq(3'b110, 3'b001, 24'h0FFFFF, 24'h0);
        chk("b2b_done",  32'(t_done), 32'h808080);
        chk("b2b_busy",  32'(t_busy), 32'hFEFEFE);
        chk("b2b_eval",  32'(t_eval), 32'h787878);
        chk("b2b_res1",  32'(t_res[7]),  32'd1);
        chk("b2b_g2",    32'(t_g[12]),   32'd1);
        chk("b2b_res2",  32'(t_res[15]), 32'd0);
        repeat (2) @(negedge clk);
        chk("b2b_idle",  32'(bus.busy), 32'd0);

`ifdef DYN_SEQ_CHECK_EN
        // Stuck-at-0 gate with exp_y=1 flags err in DONE.
        stuck0 = 1'b1;
        bus.exp_y = 1'b1;
        run_seq(3'b111, 3'b111, 24'h000001, 24'h0);
        chk("chk_err_set", 32'(t_err[7]), 32'd1);
        chk("chk_res0",    32'(t_res[7]), 32'd0);
        stuck0 = 1'b0;
        run_seq(3'b111, 3'b111, 24'h000001, 24'h0);
        chk("chk_err_clr", 32'(t_err[1]), 32'd0);
        chk("chk_err_ok",  32'(t_err[7]), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
